// File: rtl/sevseg_pkg.sv
// sevseg_pkg: shared seven-segment codes, scan-decoder FSM states and a one-hot helper.
//   SEG_0..SEG_F : active-low segment patterns, bit order [6:0] = g..a
//   state_e      : SEARCH (no valid select), SETTLE (counting a dwell), CAPTURED (dwell consumed)
//   is_onehot    : true when exactly one bit of the zero-extended vector is set
package sevseg_pkg;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    typedef enum logic [1:0] {
        SEARCH,
        SETTLE,
        CAPTURED
    } state_e;

    function automatic logic is_onehot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/sevseg_pattern_decode.sv
// sevseg_pattern_decode: combinational active-low segment pattern -> hex nibble.
//   seg_i    : segments [6:0] = g..a, active low (DP excluded)
//   valid_o  : 1 when seg_i is one of the sixteen hex glyphs
//   nibble_o : decoded value, 0 when valid_o is 0
module sevseg_pattern_decode
    import sevseg_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic       valid_o,
    output logic [3:0] nibble_o
);

    always_comb begin
        valid_o  = 1'b1;
        nibble_o = 4'h0;
        case (seg_i)
            SEG_0:   nibble_o = 4'h0;
            SEG_1:   nibble_o = 4'h1;
            SEG_2:   nibble_o = 4'h2;
            SEG_3:   nibble_o = 4'h3;
            SEG_4:   nibble_o = 4'h4;
            SEG_5:   nibble_o = 4'h5;
            SEG_6:   nibble_o = 4'h6;
            SEG_7:   nibble_o = 4'h7;
            SEG_8:   nibble_o = 4'h8;
            SEG_9:   nibble_o = 4'h9;
            SEG_A:   nibble_o = 4'hA;
            SEG_B:   nibble_o = 4'hB;
            SEG_C:   nibble_o = 4'hC;
            SEG_D:   nibble_o = 4'hD;
            SEG_E:   nibble_o = 4'hE;
            SEG_F:   nibble_o = 4'hF;
            default: valid_o  = 1'b0;
        endcase
    end

endmodule

// File: rtl/sevseg_scan_decoder.sv
// sevseg_scan_decoder: snoops a multiplexed active-low 7-seg bus, debounces each digit dwell,
// decodes it and publishes the reassembled word on a valid/ready port.
//   clk, rst       : clock, synchronous active-high reset
//   seg_in_i       : active-low segments, [6:0] = g..a, [7] = DP
//   dig_sel_n_i    : active-low digit selects, exactly one low is a valid dwell
//   data_out_o     : published word, digit i in [4i+3:4i]
//   dp_out_o       : published DP per digit (1 = lit)
//   data_valid_o   : frame available, held until data_ready_i
//   data_ready_i   : consumer accept
//   err_mask_o     : sticky, bit i set on an undecodable pattern at digit i
//   overrun_o      : sticky, a frame was dropped while data_valid_o was pending
//   err_clr_i      : clears err_mask_o and overrun_o (a same-edge set wins)
module sevseg_scan_decoder
    import sevseg_pkg::*;
#(
    parameter int NDIG          = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        seg_in_i,
    input  logic [NDIG-1:0]   dig_sel_n_i,
    output logic [4*NDIG-1:0] data_out_o,
    output logic [NDIG-1:0]   dp_out_o,
    output logic              data_valid_o,
    input  logic              data_ready_i,
    output logic [NDIG-1:0]   err_mask_o,
    output logic              overrun_o,
    input  logic              err_clr_i
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);

    logic [7:0]        seg_q;
    logic [NDIG-1:0]   sel_q;
    logic [NDIG-1:0]   sel_act;
    logic [CW-1:0]     cnt_q, cnt_d;
    state_e            state_q, state_d;
    logic              changed, sel_onehot, capture, publish, drop, load;
    logic              dec_valid;
    logic [3:0]        dec_nib;
    logic [NDIG-1:0]   seen_q, seen_d, new_err;
    logic [NDIG-1:0]   dp_sh_q, dp_sh_d, dp_q, err_q;
    logic [4*NDIG-1:0] shadow_q, shadow_d, data_q;
    logic              valid_q, ovr_q;

    sevseg_pattern_decode u_dec (
        .seg_i    (seg_q[6:0]),
        .valid_o  (dec_valid),
        .nibble_o (dec_nib)
    );

    // The incoming sample is compared against the registered one, so a value held from
    // edge k reaches STABLE_CYCLES identical samples exactly at edge k+STABLE_CYCLES.
    assign changed    = {seg_in_i, dig_sel_n_i} != {seg_q, sel_q};
    assign sel_act    = ~dig_sel_n_i;
    assign sel_onehot = is_onehot(32'(sel_act));
    assign cnt_d      = changed ? '0 : (cnt_q == CW'(STABLE_CYCLES) ? cnt_q : cnt_q + CW'(1));

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            SEARCH:   state_d = sel_onehot ? SETTLE : SEARCH;
            SETTLE: begin
                if (changed) begin
                    state_d = sel_onehot ? SETTLE : SEARCH;
                end else if (cnt_d == CW'(STABLE_CYCLES)) begin
                    capture = 1'b1;
                    state_d = CAPTURED;
                end
            end
            CAPTURED: if (changed) state_d = sel_onehot ? SETTLE : SEARCH;
            default:  state_d = SEARCH;
        endcase
    end

    // A frame is complete once every digit has been captured at least once; the
    // publish happens on the edge after the last capture.
    assign publish = &seen_q;

    always_comb begin
        shadow_d = shadow_q;
        dp_sh_d  = dp_sh_q;
        new_err  = '0;
        seen_d   = publish ? '0 : seen_q;
        for (int i = 0; i < NDIG; i++) begin
            if (capture && !sel_q[i]) begin
                seen_d[i] = 1'b1;
                if (dec_valid) begin
                    shadow_d[4*i +: 4] = dec_nib;
                    dp_sh_d[i]         = ~seg_q[7];
                end else begin
                    new_err[i] = 1'b1;
                end
            end
        end
    end

    // A consumer accept on the publish edge frees the slot, so the new frame loads.
    assign drop = publish && valid_q && !data_ready_i;
    assign load = publish && !drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q    <= '0;
            sel_q    <= '0;
            cnt_q    <= '0;
            state_q  <= SEARCH;
            seen_q   <= '0;
            shadow_q <= '0;
            dp_sh_q  <= '0;
            data_q   <= '0;
            dp_q     <= '0;
            valid_q  <= 1'b0;
            err_q    <= '0;
            ovr_q    <= 1'b0;
        end else begin
            seg_q    <= seg_in_i;
            sel_q    <= dig_sel_n_i;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            seen_q   <= seen_d;
            shadow_q <= shadow_d;
            dp_sh_q  <= dp_sh_d;
            data_q   <= load ? shadow_q : data_q;
            dp_q     <= load ? dp_sh_q : dp_q;
            valid_q  <= load || (valid_q && !data_ready_i);
            err_q    <= (err_clr_i ? '0 : err_q) | new_err;
            ovr_q    <= (ovr_q && !err_clr_i) || drop;
        end
    end

    assign data_out_o   = data_q;
    assign dp_out_o     = dp_q;
    assign data_valid_o = valid_q;
    assign err_mask_o   = err_q;
    assign overrun_o    = ovr_q;

endmodule

// File: tb/tb_sevseg_scan_decoder.sv
// tb_sevseg_scan_decoder: directed scenarios plus randomized dwells checked against a
// run-length reference model of the scan decoder.
module tb_sevseg_scan_decoder;

    localparam int SC = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  seg_in = 8'hFF;
    logic [7:0]  dig_sel_n = 8'hFF;
    logic        data_ready = 1'b0;
    logic        err_clr = 1'b0;
    logic [31:0] data_out;
    logic [7:0]  dp_out;
    logic        data_valid;
    logic [7:0]  err_mask;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    logic [6:0] codes [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic [15:0] m_prev;
    int          m_run;
    logic [7:0]  m_seen, m_dpsh, m_dp, m_err;
    logic [31:0] m_sh, m_data;
    logic        m_valid, m_ovr;

    always #5 clk = ~clk;

    sevseg_scan_decoder #(.NDIG(8), .STABLE_CYCLES(SC)) dut (
        .clk          (clk),
        .rst          (rst),
        .seg_in_i     (seg_in),
        .dig_sel_n_i  (dig_sel_n),
        .data_out_o   (data_out),
        .dp_out_o     (dp_out),
        .data_valid_o (data_valid),
        .data_ready_i (data_ready),
        .err_mask_o   (err_mask),
        .overrun_o    (overrun),
        .err_clr_i    (err_clr)
    );

    // Drives one cycle of inputs and advances the model by one edge: a digit is captured
    // when the same one-hot sample has been seen for exactly SC consecutive edges after a change.
    task automatic cyc(input logic [7:0] s, input logic [7:0] d, input logic rdy,
                       input logic clr, input logic r);
        logic [7:0] nerr;
        logic       drop, found;
        int         idx, low;
        seg_in = s;
        dig_sel_n = d;
        data_ready = rdy;
        err_clr = clr;
        rst = r;
        if (r) begin
            m_prev = '0; m_run = 0; m_seen = '0; m_sh = '0; m_dpsh = '0;
            m_data = '0; m_dp = '0; m_valid = 1'b0; m_err = '0; m_ovr = 1'b0;
        end else begin
            nerr = '0;
            drop = 1'b0;
            if (m_seen == 8'hFF) begin
                if (m_valid && !rdy) drop = 1'b1;
                else begin
                    m_data = m_sh;
                    m_dp = m_dpsh;
                    m_valid = 1'b1;
                end
                m_seen = '0;
            end else if (m_valid && rdy) begin
                m_valid = 1'b0;
            end
            m_ovr = (m_ovr && !clr) || drop;
            m_run = ({s, d} == m_prev) ? (m_run < 1000 ? m_run + 1 : m_run) : 0;
            m_prev = {s, d};
            low = 0;
            idx = 0;
            for (int i = 0; i < 8; i++) if (!d[i]) begin low++; idx = i; end
            if (m_run == SC && low == 1) begin
                found = 1'b0;
                for (int k = 0; k < 16; k++) begin
                    if (codes[k] == s[6:0]) begin
                        found = 1'b1;
                        m_sh[4*idx +: 4] = 4'(k);
                        m_dpsh[idx] = ~s[7];
                    end
                end
                if (!found) nerr[idx] = 1'b1;
                m_seen[idx] = 1'b1;
            end
            m_err = (clr ? 8'h00 : m_err) | nerr;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic dwell(input int dig, input logic [7:0] s, input int n, input logic rdy);
        for (int j = 0; j < n; j++) cyc(s, ~(8'h01 << dig), rdy, 1'b0, 1'b0);
    endtask

    // Six-cycle dwells on digits 0..7; the publish edge is the last cycle of digit 7.
    task automatic scan_word(input logic [31:0] w, input logic rdy_pub);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 6; j++)
                cyc({1'b1, codes[w[4*i +: 4]]}, ~(8'h01 << i), rdy_pub && i == 7 && j == 5,
                    1'b0, 1'b0);
    endtask

    task automatic drain();
        cyc(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        cyc(8'h00, 8'hFF, 1'b0, 1'b0, 1'b1);
        cyc(8'h00, 8'hFF, 1'b0, 1'b0, 1'b1);
        cyc(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
        checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", data_out); end
        checks++; if (dp_out !== 8'h0) begin errors++; $display("FAIL reset_dp got %h exp 0", dp_out); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", data_valid); end
        checks++; if (err_mask !== 8'h0) begin errors++; $display("FAIL reset_err got %h exp 0", err_mask); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b exp 0", overrun); end
    endtask

    task automatic test_scan();
        scan_word(32'h87654321, 1'b0);
        checks++; if (data_out !== 32'h87654321) begin errors++; $display("FAIL scan_data got %h exp 87654321", data_out); end
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL scan_valid got %b exp 1", data_valid); end
        checks++; if (dp_out !== 8'h00) begin errors++; $display("FAIL scan_dp got %h exp 00", dp_out); end
        checks++; if (err_mask !== 8'h00) begin errors++; $display("FAIL scan_err got %h exp 00", err_mask); end
        cyc(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);
        cyc(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL scan_hold got %b exp 1", data_valid); end
        drain();
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL scan_accept got %b exp 0", data_valid); end
    endtask

    task automatic test_short_dwell();
        logic [31:0] w;
        w = 32'h0FEDCBA9;
        for (int i = 0; i < 8; i++) dwell(i, {1'b1, codes[w[4*i +: 4]]}, i == 2 ? 3 : 6, 1'b0);
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL short_nopub got %b exp 0", data_valid); end
        dwell(2, {1'b1, codes[w[11:8]]}, 6, 1'b0);
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL short_pub got %b exp 1", data_valid); end
        checks++; if (data_out !== w) begin errors++; $display("FAIL short_data got %h exp %h", data_out, w); end
        drain();
    endtask

    task automatic test_error();
        for (int i = 0; i < 8; i++) dwell(i, i == 5 ? 8'hFF : {1'b1, codes[15]}, 6, 1'b0);
        checks++; if (err_mask !== 8'h20) begin errors++; $display("FAIL err_mask got %h exp 20", err_mask); end
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL err_valid got %b exp 1", data_valid); end
        checks++; if (data_out !== 32'hFFEFFFFF) begin errors++; $display("FAIL err_data got %h exp FFEFFFFF", data_out); end
        cyc(8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0);
        checks++; if (err_mask !== 8'h00) begin errors++; $display("FAIL err_clr got %h exp 00", err_mask); end
    endtask

    task automatic test_overrun();
        scan_word(32'h13579BDF, 1'b0);
        scan_word(32'h2468ACE0, 1'b0);
        checks++; if (data_out !== 32'h13579BDF) begin errors++; $display("FAIL ovr_hold got %h exp 13579BDF", data_out); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b exp 1", overrun); end
        cyc(8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr got %b exp 0", overrun); end
        scan_word(32'h2468ACE0, 1'b1);
        checks++; if (data_out !== 32'h2468ACE0) begin errors++; $display("FAIL b2b_data got %h exp 2468ACE0", data_out); end
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b exp 1", data_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_ovr got %b exp 0", overrun); end
        drain();
    endtask

    task automatic test_multi_sel();
        for (int i = 0; i < 7; i++) dwell(i, {1'b1, codes[1]}, 6, 1'b0);
        for (int j = 0; j < 10; j++) cyc({1'b1, codes[3]}, 8'hFC, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 10; j++) cyc({1'b1, codes[3]}, 8'hFF, 1'b0, 1'b0, 1'b0);
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL msel_valid got %b exp 0", data_valid); end
        checks++; if (err_mask !== 8'h00) begin errors++; $display("FAIL msel_err got %h exp 00", err_mask); end
        dwell(7, {1'b1, codes[9]}, 6, 1'b0);
        checks++; if (data_out !== 32'h91111111) begin errors++; $display("FAIL msel_data got %h exp 91111111", data_out); end
        drain();
    endtask

    task automatic test_reset_mid();
        dwell(3, {1'b1, codes[5]}, 2, 1'b0);
        cyc({1'b1, codes[5]}, 8'hF7, 1'b0, 1'b0, 1'b1);
        checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL rmid_data got %h exp 0", data_out); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b exp 0", data_valid); end
        dwell(3, {1'b1, codes[5]}, 3, 1'b0);
        dwell(0, 8'h79, 6, 1'b0);
        for (int i = 1; i < 8; i++) if (i != 3) dwell(i, {1'b1, codes[2]}, 6, 1'b0);
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL rmid_partial got %b exp 0", data_valid); end
        dwell(3, {1'b1, codes[5]}, 6, 1'b0);
        checks++; if (data_out !== 32'h22225221) begin errors++; $display("FAIL rmid_word got %h exp 22225221", data_out); end
        checks++; if (dp_out !== 8'h01) begin errors++; $display("FAIL rmid_dp got %h exp 01", dp_out); end
        drain();
    endtask

    task automatic test_random();
        logic [7:0] s, d;
        int         n;
        for (int t = 0; t < 250; t++) begin
            s = $urandom_range(0, 5) == 0 ? 8'($urandom) : {1'($urandom), codes[$urandom_range(0, 15)]};
            d = $urandom_range(0, 7) == 0 ? 8'($urandom) : ~(8'h01 << $urandom_range(0, 7));
            n = $urandom_range(1, 7);
            for (int j = 0; j < n; j++) begin
                cyc(s, d, $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, 1'b0);
                checks++; if (data_out !== m_data) begin errors++; $display("FAIL rnd_data t=%0d got %h exp %h", t, data_out, m_data); end
                checks++; if (dp_out !== m_dp) begin errors++; $display("FAIL rnd_dp t=%0d got %h exp %h", t, dp_out, m_dp); end
                checks++; if (data_valid !== m_valid) begin errors++; $display("FAIL rnd_valid t=%0d got %b exp %b", t, data_valid, m_valid); end
                checks++; if (err_mask !== m_err) begin errors++; $display("FAIL rnd_err t=%0d got %h exp %h", t, err_mask, m_err); end
                checks++; if (overrun !== m_ovr) begin errors++; $display("FAIL rnd_ovr t=%0d got %b exp %b", t, overrun, m_ovr); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_short_dwell();
        test_error();
        test_overrun();
        test_multi_sel();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
